// File: rtl/memory_access.sv
// Memory stage of the pipeline: E->M pipeline register, data-bus request FSM,
// store lane/strobe formatting and load alignment/extension.
module memory_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        StallM,
  input  logic        FlushM,
  input  logic [31:0] PCE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] HiDataE,
  input  logic [31:0] LoDataE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        HiWriteE,
  input  logic        LoWriteE,
  input  logic        SignedE,
  input  logic [1:0]  SizeE,
  output logic [31:0] PCM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [31:0] HiDataM,
  output logic [31:0] LoDataM,
  output logic [4:0]  WriteRegM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic        HiWriteM,
  output logic        LoWriteM,
  output logic        SignedM,
  output logic [1:0]  SizeM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic        dvalid,
  output logic [31:0] daddr,
  output logic [1:0]  dsize,
  output logic [3:0]  dstrobe,
  output logic [31:0] dwdata,
  input  logic        daddr_ok,
  input  logic        ddata_ok,
  input  logic [31:0] drdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc;
  logic [31:0] r_aluout;
  logic [31:0] r_wdata;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_wreg;
  logic        r_regwrite;
  logic        r_memtoreg;
  logic        r_memwrite;
  logic        r_hiwrite;
  logic        r_lowrite;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_rdata;
  logic        r_flush_pend;

  logic        w_memop;
  logic        w_in_flight;
  logic        w_drain;
  logic        w_flush_req;
  logic        w_block;
  logic        w_bubble;
  logic        w_load;
  logic        w_dvalid;
  logic [1:0]  w_off;
  logic [31:0] w_raw;
  logic [31:0] w_shift;

  // A memory op is outstanding until its data phase completes; while it is
  // outstanding a flush may not replace the register (the bus must drain).
  assign w_memop     = r_memtoreg | r_memwrite;
  assign w_in_flight = (r_state != S_HOLD);
  assign w_drain     = w_memop & w_in_flight & ~ddata_ok;
  assign w_flush_req = FlushM | r_flush_pend;
  assign w_block     = w_drain & w_flush_req;
  assign w_bubble    = w_flush_req & ~w_drain;
  assign w_load      = ~w_block & (w_bubble | ~StallM);

  assign MemStallM   = w_drain;
  assign w_off       = r_aluout[1:0];

  // E->M pipeline register; a bubble keeps data fields but clears control bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc       <= '0;
      r_aluout   <= '0;
      r_wdata    <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_wreg     <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_memwrite <= 1'b0;
      r_hiwrite  <= 1'b0;
      r_lowrite  <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= '0;
    end else if (w_load) begin
      r_pc       <= PCE;
      r_aluout   <= ALUOutE;
      r_wdata    <= WriteDataE;
      r_hi       <= HiDataE;
      r_lo       <= LoDataE;
      r_wreg     <= WriteRegE;
      r_signed   <= SignedE;
      r_size     <= SizeE;
      r_regwrite <= w_bubble ? 1'b0 : RegWriteE;
      r_memtoreg <= w_bubble ? 1'b0 : MemtoRegE;
      r_memwrite <= w_bubble ? 1'b0 : MemWriteE;
      r_hiwrite  <= w_bubble ? 1'b0 : HiWriteE;
      r_lowrite  <= w_bubble ? 1'b0 : LoWriteE;
    end
  end

  // Remember a flush that arrived while the bus was still draining.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flush_pend <= 1'b0;
    end else if (w_load) begin
      r_flush_pend <= 1'b0;
    end else if (FlushM && w_drain) begin
      r_flush_pend <= 1'b1;
    end
  end

  // Capture load data on the data handshake unless the op is being flushed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= '0;
    end else if (ddata_ok && w_memop && w_in_flight && r_memtoreg && !w_flush_req) begin
      r_rdata <= drdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and request valid; any register advance restarts at IDLE.
  always_comb begin
    w_state_next = r_state;
    w_dvalid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          w_dvalid = 1'b1;
          if (daddr_ok && ddata_ok) begin
            w_state_next = S_HOLD;
          end else if (daddr_ok) begin
            w_state_next = S_WAIT;
          end else begin
            w_state_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_dvalid = w_memop;
        if (daddr_ok && ddata_ok) begin
          w_state_next = S_HOLD;
        end else if (daddr_ok) begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ddata_ok) begin
          w_state_next = S_HOLD;
        end
      end
      default: begin
        w_state_next = S_HOLD;
      end
    endcase
    if (w_load) begin
      w_state_next = S_IDLE;
    end
  end

  assign dvalid = w_dvalid;
  assign daddr  = r_aluout;
  assign dsize  = r_size;

  // Store byte-lane strobes and lane-replicated write data.
  always_comb begin
    dstrobe = 4'b0000;
    dwdata  = r_wdata;
    case (r_size)
      2'b00: begin
        dwdata = {4{r_wdata[7:0]}};
        if (r_memwrite) dstrobe = 4'b0001 << w_off;
      end
      2'b01: begin
        dwdata = {2{r_wdata[15:0]}};
        if (r_memwrite) dstrobe = 4'b0011 << {w_off[1], 1'b0};
      end
      default: begin
        dwdata = r_wdata;
        if (r_memwrite) dstrobe = 4'b1111;
      end
    endcase
  end

  // Load alignment: shift the addressed lane down, then sign/zero extend.
  assign w_raw   = (ddata_ok && w_memop && w_in_flight) ? drdata : r_rdata;
  assign w_shift = w_raw >> {w_off, 3'b000};

  always_comb begin
    ReadDataM = w_shift;
    case (r_size)
      2'b00:   ReadDataM = r_signed ? {{24{w_shift[7]}}, w_shift[7:0]}
                                    : {24'd0, w_shift[7:0]};
      2'b01:   ReadDataM = r_signed ? {{16{w_shift[15]}}, w_shift[15:0]}
                                    : {16'd0, w_shift[15:0]};
      default: ReadDataM = w_shift;
    endcase
  end

  assign PCM        = r_pc;
  assign ALUOutM    = r_aluout;
  assign WriteDataM = r_wdata;
  assign HiDataM    = r_hi;
  assign LoDataM    = r_lo;
  assign WriteRegM  = r_wreg;
  assign RegWriteM  = r_regwrite;
  assign MemtoRegM  = r_memtoreg;
  assign MemWriteM  = r_memwrite;
  assign HiWriteM   = r_hiwrite;
  assign LoWriteM   = r_lowrite;
  assign SignedM    = r_signed;
  assign SizeM      = r_size;

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access: a word-array memory doubles as the bus
// slave and the reference for load results; a hazard-unit stand-in drives
// StallM from MemStallM plus optional extra hold cycles.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        resetn, StallM, FlushM;
  logic [31:0] PCE, ALUOutE, WriteDataE, HiDataE, LoDataE;
  logic [4:0]  WriteRegE;
  logic        RegWriteE, MemtoRegE, MemWriteE, HiWriteE, LoWriteE, SignedE;
  logic [1:0]  SizeE;
  logic [31:0] PCM, ALUOutM, WriteDataM, HiDataM, LoDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, MemtoRegM, MemWriteM, HiWriteM, LoWriteM, SignedM;
  logic [1:0]  SizeM;
  logic [31:0] ReadDataM;
  logic        MemStallM, dvalid;
  logic [31:0] daddr, dwdata;
  logic [1:0]  dsize;
  logic [3:0]  dstrobe;
  logic        daddr_ok, ddata_ok;
  logic [31:0] drdata;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .resetn(resetn), .StallM(StallM), .FlushM(FlushM),
    .PCE(PCE), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .HiDataE(HiDataE),
    .LoDataE(LoDataE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .HiWriteE(HiWriteE),
    .LoWriteE(LoWriteE), .SignedE(SignedE), .SizeE(SizeE),
    .PCM(PCM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .HiDataM(HiDataM),
    .LoDataM(LoDataM), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
    .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .HiWriteM(HiWriteM),
    .LoWriteM(LoWriteM), .SignedM(SignedM), .SizeM(SizeM),
    .ReadDataM(ReadDataM), .MemStallM(MemStallM), .dvalid(dvalid),
    .daddr(daddr), .dsize(dsize), .dstrobe(dstrobe), .dwdata(dwdata),
    .daddr_ok(daddr_ok), .ddata_ok(ddata_ok), .drdata(drdata)
  );

  typedef struct {
    logic [31:0] pc, addr, wd, hi, lo;
    logic [4:0]  wr;
    logic        rw, m2r, mw, hw, lw, sg;
    logic [1:0]  sz;
    int          la, ld, extra, flush_at;
  } op_t;

  op_t         ops [0:63];
  logic [31:0] mem [0:255];
  int          total = 0;
  int          bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic op_t mk_op(input int kind, input logic [31:0] addr, input logic [1:0] sz,
                                input logic sg, input logic [31:0] wd,
                                input int la, input int ld, input int extra, input int flush_at);
    op_t o;
    o.pc = $urandom; o.addr = addr; o.wd = wd; o.hi = $urandom; o.lo = $urandom;
    o.wr = 5'($urandom);
    o.rw = (kind == 1) ? 1'b1 : ((kind == 2) ? 1'b0 : 1'($urandom));
    o.m2r = (kind == 1); o.mw = (kind == 2);
    o.hw = 1'($urandom); o.lw = 1'($urandom);
    o.sg = sg; o.sz = sz;
    o.la = la; o.ld = ld; o.extra = extra; o.flush_at = flush_at;
    return o;
  endfunction

  function automatic op_t rand_op();
    int kind, la, ld, ex, fa;
    logic [1:0] sz, off;
    logic [7:0] idx;
    kind = $urandom_range(0, 2);
    sz   = 2'($urandom_range(0, 2));
    idx  = 8'($urandom_range(0, 255));
    if (sz == 2'd0)      off = 2'($urandom_range(0, 3));
    else if (sz == 2'd1) off = {1'($urandom_range(0, 1)), 1'b0};
    else                 off = 2'b00;
    la = $urandom_range(0, 3);
    ld = $urandom_range(0, 3);
    ex = $urandom_range(0, 2);
    fa = -1;
    if (kind != 0 && (la + ld) > 0 && $urandom_range(0, 4) == 0) begin
      fa = $urandom_range(0, la + ld - 1);
      ex = 0;
    end
    if (kind == 0) return mk_op(0, $urandom, sz, 1'($urandom), $urandom, 0, 0, ex, -1);
    return mk_op(kind, {22'd0, idx, off}, sz, 1'($urandom), $urandom, la, ld, ex, fa);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    v = word >> (8 * int'(off));
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sg && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  function automatic logic [3:0] exp_strobe(input op_t o);
    if (!o.mw) return 4'b0000;
    if (o.sz == 2'd0) return 4'(1 << int'(o.addr[1:0]));
    if (o.sz == 2'd1) return o.addr[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input op_t o);
    if (o.sz == 2'd0) return (o.wd & 32'hFF) * 32'h01010101;
    if (o.sz == 2'd1) return (o.wd & 32'hFFFF) * 32'h00010001;
    return o.wd;
  endfunction

  task automatic mem_store(input op_t o);
    int sh;
    logic [31:0] mask;
    sh = 8 * int'(o.addr[1:0]);
    if (o.sz == 2'd0)      mask = 32'hFF << sh;
    else if (o.sz == 2'd1) mask = 32'hFFFF << sh;
    else                   mask = 32'hFFFFFFFF;
    mem[o.addr[9:2]] = (mem[o.addr[9:2]] & ~mask) | ((o.wd << sh) & mask);
  endtask

  task automatic drive_e(input op_t o);
    PCE = o.pc; ALUOutE = o.addr; WriteDataE = o.wd; HiDataE = o.hi; LoDataE = o.lo;
    WriteRegE = o.wr; RegWriteE = o.rw; MemtoRegE = o.m2r; MemWriteE = o.mw;
    HiWriteE = o.hw; LoWriteE = o.lw; SignedE = o.sg; SizeE = o.sz;
  endtask

  task automatic check_m(input op_t o);
    check_eq("pcm", PCM, o.pc);
    check_eq("aluoutm", ALUOutM, o.addr);
    check_eq("wdatam", WriteDataM, o.wd);
    check_eq("hidatam", HiDataM, o.hi);
    check_eq("lodatam", LoDataM, o.lo);
    check_eq("wregm", 32'(WriteRegM), 32'(o.wr));
    check_eq("ctlm", 32'({RegWriteM, MemtoRegM, MemWriteM, HiWriteM, LoWriteM, SignedM, SizeM}),
             32'({o.rw, o.m2r, o.mw, o.hw, o.lw, o.sg, o.sz}));
  endtask

  // Runs one instruction sitting in M; entered and left at posedge+1.
  task automatic m_phase(input op_t o, output bit flushed);
    bit memop, ld_op;
    int dcyc, extra, nv, ns;
    logic [7:0] idx;
    logic [31:0] exp_rd;
    memop   = o.m2r | o.mw;
    ld_op   = o.m2r;
    dcyc    = memop ? (o.la + o.ld) : 0;
    flushed = memop && (o.flush_at >= 0);
    extra   = flushed ? 0 : o.extra;
    idx     = o.addr[9:2];
    exp_rd  = exp_load(mem[idx], o.addr[1:0], o.sz, o.sg);
    nv = 0; ns = 0;
    for (int k = 0; k <= dcyc; k++) begin
      daddr_ok = memop && (k == o.la);
      ddata_ok = memop && (k == dcyc);
      drdata   = (ddata_ok && ld_op) ? mem[idx] : $urandom;
      FlushM   = memop && (k == o.flush_at);
      #1;
      StallM = MemStallM | ((k == dcyc) && (extra > 0));
      #1;
      check_eq("dvalid", 32'(dvalid), 32'(memop && (k <= o.la)));
      check_eq("memstall", 32'(MemStallM), 32'(memop && (k < dcyc)));
      if (dvalid) nv++;
      if (MemStallM) ns++;
      if (memop && k <= o.la) begin
        check_eq("daddr", daddr, o.addr);
        check_eq("dsize", 32'(dsize), 32'(o.sz));
        check_eq("dstrobe", 32'(dstrobe), 32'(exp_strobe(o)));
        check_eq("dwdata", dwdata, exp_wdata(o));
      end
      if (k == dcyc) begin
        if (ld_op && !flushed) check_eq("rdata", ReadDataM, exp_rd);
        if (o.mw) mem_store(o);
      end
      @(posedge clk); #1;
    end
    daddr_ok = 1'b0; ddata_ok = 1'b0; FlushM = 1'b0;
    check_eq("nvalid", 32'(nv), memop ? 32'(o.la + 1) : 32'd0);
    check_eq("nstall", 32'(ns), 32'(dcyc));
    for (int e = 0; e < extra; e++) begin
      StallM = (e < extra - 1);
      drdata = $urandom;
      #2;
      check_eq("hold_dvalid", 32'(dvalid), 32'd0);
      check_eq("hold_memstall", 32'(MemStallM), 32'd0);
      if (ld_op) check_eq("hold_rdata", ReadDataM, exp_rd);
      @(posedge clk); #1;
    end
    StallM = 1'b0;
  endtask

  task automatic run_ops(input int n);
    op_t nx;
    bit fl;
    drive_e(ops[0]); StallM = 1'b0;
    @(posedge clk); #1;
    check_m(ops[0]);
    for (int i = 0; i < n; i++) begin
      if (i + 1 < n) nx = ops[i + 1];
      else           nx = mk_op(0, $urandom, 2'd0, 1'b0, $urandom, 0, 0, 0, -1);
      drive_e(nx);
      m_phase(ops[i], fl);
      if (fl) begin
        nx.rw = 1'b0; nx.m2r = 1'b0; nx.mw = 1'b0; nx.hw = 1'b0; nx.lw = 1'b0;
        if (i + 1 < n) ops[i + 1] = nx;
      end
      check_m(nx);
      $display("op %0d: %s addr=%h size=%0d la=%0d ld=%0d extra=%0d%s", i,
               ops[i].m2r ? "load " : (ops[i].mw ? "store" : "alu  "), ops[i].addr,
               ops[i].sz, ops[i].la, ops[i].ld, ops[i].extra, fl ? " flushed" : "");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t r;
    resetn = 1'b0; StallM = 1'b0; FlushM = 1'b0;
    daddr_ok = 1'b0; ddata_ok = 1'b0; drdata = '0;
    drive_e(mk_op(1, 32'h104, 2'd2, 1'b0, 32'h0, 0, 0, 0, -1));
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[32'h100 >> 2] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dvalid", 32'(dvalid), 32'd0);
    check_eq("rst_memstall", 32'(MemStallM), 32'd0);
    check_eq("rst_dstrobe", 32'(dstrobe), 32'd0);
    check_eq("rst_pcm", PCM, 32'd0);
    check_eq("rst_regwrite", 32'(RegWriteM), 32'd0);
    check_eq("rst_rdata", ReadDataM, 32'd0);
    resetn = 1'b1;

    ops[0] = mk_op(1, 32'h100, 2'd2, 1'b0, 32'h0, 0, 0, 1, -1);
    ops[1] = mk_op(2, 32'h100, 2'd2, 1'b0, 32'h80FF1234, 1, 1, 0, -1);
    ops[2] = mk_op(1, 32'h103, 2'd0, 1'b1, 32'h0, 0, 2, 2, -1);
    ops[3] = mk_op(1, 32'h103, 2'd0, 1'b0, 32'h0, 1, 0, 0, -1);
    ops[4] = mk_op(2, 32'h202, 2'd1, 1'b0, 32'h0000ABCD, 0, 0, 0, -1);
    ops[5] = mk_op(1, 32'h200, 2'd2, 1'b0, 32'h0, 2, 3, 1, -1);
    ops[6] = mk_op(1, 32'h300, 2'd2, 1'b0, 32'h0, 1, 3, 0, 2);
    ops[7] = mk_op(0, 32'h12345678, 2'd2, 1'b0, 32'h0, 0, 0, 0, -1);
    ops[7].rw = 1'b1;
    for (int i = 8; i < 48; i++) ops[i] = rand_op();
    run_ops(48);

    // Reset while the load waits for its data phase.
    r = mk_op(1, 32'h100, 2'd2, 1'b0, 32'h0, 0, 5, 0, -1);
    drive_e(r); StallM = 1'b0;
    @(posedge clk); #1;
    drive_e(mk_op(0, $urandom, 2'd0, 1'b0, $urandom, 0, 0, 0, -1));
    daddr_ok = 1'b1;
    #1 StallM = MemStallM;
    @(posedge clk); #1;
    daddr_ok = 1'b0;
    #1;
    check_eq("wait_memstall", 32'(MemStallM), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("arst_dvalid", 32'(dvalid), 32'd0);
    check_eq("arst_memstall", 32'(MemStallM), 32'd0);
    check_eq("arst_dstrobe", 32'(dstrobe), 32'd0);
    check_eq("arst_daddr", daddr, 32'd0);
    check_eq("arst_ctl", 32'({RegWriteM, MemtoRegM, MemWriteM}), 32'd0);
    check_eq("arst_pcm", PCM, 32'd0);
    check_eq("arst_rdata", ReadDataM, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; StallM = 1'b0;

    ops[0] = mk_op(1, 32'h100, 2'd2, 1'b0, 32'h0, 1, 1, 1, -1);
    for (int i = 1; i < 20; i++) ops[i] = rand_op();
    run_ops(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
